// File: rtl/multi_dataflow_stream_tracker.sv
// Tracks beats on N_OUT output streams against a programmed length, sequences
// kernel start/done and produces last-beat byte strobes plus status flags.
module multi_dataflow_stream_tracker #(
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAIL_W = $clog2(DATA_W/8)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic [ID_W-1:0]             id_i,
    input  logic [CNT_W-1:0]            len_i,
    input  logic [TAIL_W-1:0]           tail_i,
    input  logic [N_OUT-1:0]            out_valid_i,
    input  logic [N_OUT-1:0]            out_ready_i,
    output logic [N_OUT*(DATA_W/8)-1:0] strb_o,
    output logic [N_OUT*CNT_W-1:0]      cnt_o,
    output logic                        k_start_o,
    output logic [ID_W-1:0]             k_id_o,
    input  logic                        k_ready_i,
    input  logic                        k_idle_i,
    input  logic                        k_done_i,
    output logic                        ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int unsigned SW = DATA_W/8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [N_OUT];
    logic [CNT_W-1:0]    len_q;
    logic [TAIL_W-1:0]   tail_q;
    logic [ID_W-1:0]     id_q;
    logic                kdone_q;
    logic                err_q;
    logic                ready_q;
    logic                kstart_q;
    logic                start_acc;
    logic                all_done;
    logic [N_OUT-1:0]    beat;
    logic [CNT_W-1:0]    len_m1;
    logic [SW-1:0]       tail_mask;

    assign start_acc = (state_q == IDLE) && start_i && ready_q;
    assign beat      = out_valid_i & out_ready_i;
    assign len_m1    = len_q - CNT_W'(1);
    assign tail_mask = (SW'(1) << tail_q) - SW'(1);

    always_comb begin
        all_done = 1'b1;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (cnt_q[k] != len_q) all_done = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (kdone_q && all_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion is judged on registered counts, so the last beat and done
    // become visible one cycle before DONE is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int unsigned k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
            len_q    <= '0;
            tail_q   <= '0;
            id_q     <= '0;
            kdone_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            kstart_q <= 1'b0;
        end else begin
            kstart_q <= start_acc;
            ready_q  <= (state_q == IDLE) && (k_ready_i || k_idle_i);
            if (start_acc) begin
                for (int unsigned k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
                len_q   <= len_i;
                tail_q  <= tail_i;
                id_q    <= id_i;
                kdone_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (state_q == RUN) begin
                if (k_done_i) kdone_q <= 1'b1;
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (beat[k]) begin
                        if (cnt_q[k] < len_q) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        else                  err_q    <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_o  = '0;
        strb_o = '1;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
            if ((state_q == RUN) && (tail_q != '0) && (cnt_q[k] == len_m1))
                strb_o[k*SW +: SW] = tail_mask;
        end
    end

    assign k_start_o = kstart_q;
    assign k_id_o    = id_q;
    assign ready_o   = ready_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;

endmodule

// File: tb/tb_multi_dataflow_stream_tracker.sv
// Self-checking bench: vector table of jobs plus hand sequences; completed jobs
// are checked against a scoreboard of expected counts and error flag.
module tb_multi_dataflow_stream_tracker;

    localparam int N_OUT = 2, CNT_W = 16, ID_W = 8, DATA_W = 32, SW = 4, TAIL_W = 2;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1, start_i = 1'b0, clear_i = 1'b0;
    logic [ID_W-1:0]         id_i = '0;
    logic [CNT_W-1:0]        len_i = '0;
    logic [TAIL_W-1:0]       tail_i = '0;
    logic [N_OUT-1:0]        out_valid_i = '0, out_ready_i = '0;
    logic [N_OUT*SW-1:0]     strb_o;
    logic [N_OUT*CNT_W-1:0]  cnt_o;
    logic                    k_start_o;
    logic [ID_W-1:0]         k_id_o;
    logic                    k_ready_i = 1'b1, k_idle_i = 1'b0, k_done_i = 1'b0;
    logic                    ready_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    multi_dataflow_stream_tracker #(
        .N_OUT(N_OUT), .CNT_W(CNT_W), .ID_W(ID_W), .DATA_W(DATA_W), .TAIL_W(TAIL_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .id_i(id_i), .len_i(len_i), .tail_i(tail_i),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
        .strb_o(strb_o), .cnt_o(cnt_o), .k_start_o(k_start_o), .k_id_o(k_id_o),
        .k_ready_i(k_ready_i), .k_idle_i(k_idle_i), .k_done_i(k_done_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct { int c0; int c1; bit err; } exp_t;
    typedef struct { int len; int tail; int n0; int n1; int c0; int c1; bit err; } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[5];
    int   checks = 0, errors = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done_o pulse must match a queued expectation.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no job completion");
            end else begin
                mon_e = sb.pop_front();
                chk("done_cnt0", 64'(cnt_o[0 +: CNT_W]), 64'(mon_e.c0));
                chk("done_cnt1", 64'(cnt_o[CNT_W +: CNT_W]), 64'(mon_e.c1));
                chk("done_err", 64'(err_o), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (ready_o === 1'b1) break;
            step();
        end
        chk("ready_wait", 64'(ready_o), 64'd1);
    endtask

    task automatic start_job(input int id, input int len, input int tail);
        wait_ready();
        id_i = ID_W'(id); len_i = CNT_W'(len); tail_i = TAIL_W'(tail);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("k_start", 64'(k_start_o), 64'd1);
        chk("k_id", 64'(k_id_o), 64'(id));
        chk("busy_run", 64'(busy_o), 64'd1);
        chk("err_start", 64'(err_o), 64'd0);
        chk("cnt_start", 64'(cnt_o), 64'd0);
    endtask

    task automatic beat(input logic v0, input logic r0, input logic v1, input logic r1);
        out_valid_i = {v1, v0};
        out_ready_i = {r1, r0};
        step();
        out_valid_i = '0;
        out_ready_i = '0;
    endtask

    task automatic pulse_kdone();
        k_done_i = 1'b1;
        step();
        k_done_i = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int s;
        s = done_cnt;
        for (int i = 0; i < n; i++) begin
            if (done_cnt != s) break;
            step();
        end
        chk("done_seen", 64'(done_cnt - s), 64'd1);
    endtask

    function automatic logic [3:0] exp_strb(input int cnt, input int len, input int tail);
        if (tail != 0 && cnt == len - 1) return 4'((1 << tail) - 1);
        return 4'hF;
    endfunction

    initial begin
        vt[0] = '{4, 0, 4, 4, 4, 4, 1'b0};
        vt[1] = '{2, 0, 3, 2, 2, 2, 1'b1};
        vt[2] = '{0, 0, 0, 0, 0, 0, 1'b0};
        vt[3] = '{5, 1, 5, 5, 5, 5, 1'b0};
        vt[4] = '{1, 3, 2, 1, 1, 1, 1'b1};

        // reset state
        step(); step();
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_kstart", 64'(k_start_o), 64'd0);
        chk("rst_strb", 64'(strb_o), 64'hFF);
        rst_i = 1'b0;
        chk("ready_after_rst", 64'(ready_o), 64'd0);

        // table-driven jobs
        for (int i = 0; i < 5; i++) begin
            int nmax;
            start_job(i + 1, vt[i].len, vt[i].tail);
            nmax = (vt[i].n0 > vt[i].n1) ? vt[i].n0 : vt[i].n1;
            for (int b = 0; b < nmax; b++) begin
                int m0, m1;
                if (b == 1) beat(1'b1, 1'b0, 1'b1, 1'b0);
                m0 = (b < vt[i].len) ? b : vt[i].len;
                m1 = m0;
                if (b < vt[i].n0) chk("tbl_strb0", 64'(strb_o[0 +: SW]), 64'(exp_strb(m0, vt[i].len, vt[i].tail)));
                if (b < vt[i].n1) chk("tbl_strb1", 64'(strb_o[SW +: SW]), 64'(exp_strb(m1, vt[i].len, vt[i].tail)));
                beat(b < vt[i].n0, 1'b1, b < vt[i].n1, 1'b1);
            end
            chk("tbl_err", 64'(err_o), 64'(vt[i].err));
            sb.push_back('{vt[i].c0, vt[i].c1, vt[i].err});
            pulse_kdone();
            wait_done(10);
            step();
            chk("tbl_busy_after", 64'(busy_o), 64'd0);
            chk("tbl_strb_idle", 64'(strb_o), 64'hFF);
            chk("tbl_cnt_hold", 64'(cnt_o), 64'({16'(vt[i].c1), 16'(vt[i].c0)}));
        end

        // last beats coincide with k_done: done two cycles later
        start_job(8'h21, 2, 0);
        step();
        chk("k_start_one_cycle", 64'(k_start_o), 64'd0);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        out_valid_i = 2'b11; out_ready_i = 2'b11; k_done_i = 1'b1;
        step();
        out_valid_i = '0; out_ready_i = '0; k_done_i = 1'b0;
        chk("coinc_t1", 64'(done_o), 64'd0);
        sb.push_back('{2, 2, 1'b0});
        step();
        chk("coinc_t2", 64'(done_o), 64'd1);
        step();

        // early k_done before any beat
        start_job(8'h22, 4, 0);
        pulse_kdone();
        for (int b = 0; b < 4; b++) beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("early_t1", 64'(done_o), 64'd0);
        sb.push_back('{4, 4, 1'b0});
        step();
        chk("early_t2", 64'(done_o), 64'd1);
        step();

        // tail strobe with stream 1 lagging two cycles
        start_job(8'h23, 3, 2);
        for (int c = 0; c < 5; c++) begin
            if (c < 3)  chk("tail_strb0", 64'(strb_o[0 +: SW]), 64'((c == 2) ? 4'h3 : 4'hF));
            if (c >= 2) chk("tail_strb1", 64'(strb_o[SW +: SW]), 64'((c == 4) ? 4'h3 : 4'hF));
            beat(c < 3, 1'b1, c >= 2, 1'b1);
        end
        chk("tail_strb_after", 64'(strb_o), 64'hFF);
        sb.push_back('{3, 3, 1'b0});
        pulse_kdone();
        wait_done(10);

        // overflow: sticky through DONE, cleared by next start
        start_job(8'h41, 2, 0);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("ovf_err_pre", 64'(err_o), 64'd0);
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf_err", 64'(err_o), 64'd1);
        chk("ovf_cnt0", 64'(cnt_o[0 +: CNT_W]), 64'd2);
        sb.push_back('{2, 2, 1'b1});
        pulse_kdone();
        wait_done(10);
        step();
        chk("ovf_err_sticky", 64'(err_o), 64'd1);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("idle_beat_cnt", 64'(cnt_o), 64'({16'd2, 16'd2}));

        // start gating: kernel not ready
        k_ready_i = 1'b0; k_idle_i = 1'b0;
        step(); step();
        chk("gate_ready", 64'(ready_o), 64'd0);
        id_i = 8'h55; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("gate_kstart", 64'(k_start_o), 64'd0);
        chk("gate_busy", 64'(busy_o), 64'd0);
        chk("gate_id", 64'(k_id_o), 64'h41);
        k_idle_i = 1'b1;
        // start while running is ignored; len 0 completes on k_done alone
        start_job(8'h11, 0, 0);
        id_i = 8'h99; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("run_start_kstart", 64'(k_start_o), 64'd0);
        chk("run_start_id", 64'(k_id_o), 64'h11);
        sb.push_back('{0, 0, 1'b0});
        pulse_kdone();
        wait_done(10);
        k_idle_i = 1'b0; k_ready_i = 1'b1;

        // abort by clear
        start_job(8'h31, 4, 0);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_pre_cnt", 64'(cnt_o), 64'({16'd2, 16'd2}));
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_busy", 64'(busy_o), 64'd0);
        chk("clr_cnt", 64'(cnt_o), 64'd0);
        chk("clr_id", 64'(k_id_o), 64'd0);
        chk("clr_ready", 64'(ready_o), 64'd0);
        pulse_kdone();
        for (int i = 0; i < 4; i++) step();

        // abort by reset
        start_job(8'h32, 4, 0);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_abort_busy", 64'(busy_o), 64'd0);
        chk("rst_abort_cnt", 64'(cnt_o), 64'd0);
        pulse_kdone();
        for (int i = 0; i < 4; i++) step();

        // clear coincident with start
        wait_ready();
        id_i = 8'h77; start_i = 1'b1; clear_i = 1'b1;
        step();
        start_i = 1'b0; clear_i = 1'b0;
        chk("clrstart_kstart", 64'(k_start_o), 64'd0);
        chk("clrstart_busy", 64'(busy_o), 64'd0);
        step();
        chk("clrstart_busy2", 64'(busy_o), 64'd0);
        chk("clrstart_id", 64'(k_id_o), 64'd0);

        step(); step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_dataflow_stream_tracker.md
Name: multi_dataflow_stream_tracker

Overview:
Parametrised successor to the single-output engine control logic of the multi-dataflow HWPE. The block supports N_OUT output streams. It counts accepted beats per stream against a programmed length and generates last-beat byte strobes from a programmed tail size. It sequences kernel start/done through a small FSM and reports ready, done, busy and overflow-error flags to the HWPE controller. It sits between the controller FSM and the kernel adapter, observing output-stream handshakes without modifying valid or ready.

Parameters:
N_OUT, 2, number of output streams tracked
CNT_W, 16, beat-counter and length width
ID_W, 8, kernel configuration ID width
DATA_W, 32, stream data width in bits; strobe width per stream SW = DATA_W/8
TAIL_W, $clog2(DATA_W/8), width of tail byte count

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request from controller
clear_i  in  1  soft clear from controller
id_i  in  ID_W  kernel configuration ID
len_i  in  CNT_W  expected beats per output stream
tail_i  in  TAIL_W  valid bytes in final beat; 0 = full beat
out_valid_i  in  N_OUT  observed stream valid, bit k = stream k
out_ready_i  in  N_OUT  observed stream ready
strb_o  out  N_OUT*SW  byte strobes, stream k at [k*SW +: SW]
cnt_o  out  N_OUT*CNT_W  accepted-beat counters, stream k at [k*CNT_W +: CNT_W]
k_start_o  out  1  kernel start pulse
k_id_o  out  ID_W  latched configuration ID to kernel
k_ready_i  in  1  kernel ready
k_idle_i  in  1  kernel idle
k_done_i  in  1  kernel done, may be level or pulse
ready_o  out  1  block can accept start
busy_o  out  1  job in progress
done_o  out  1  job-complete pulse
err_o  out  1  sticky overflow error

Behaviour:
- Reset and clear: rst_i has priority; clear_i is next.
- Either one sets: state IDLE; cnt_o, k_start_o, done_o, err_o, kdone_seen and ready_o to 0; k_id_o, len_q and tail_q to 0.
- clear_i in the same cycle as start_i: clear wins and start is dropped.
- Reset or clear mid-job aborts the job with no done_o.
- ready_o is registered: next value = (state==IDLE) & (k_ready_i | k_idle_i). After reset it is 0 for at least one cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_i & ready_o moves the FSM to RUN. On that edge: latch id_i, len_i, tail_i; zero all counters, err_o and kdone_seen; set k_start_o=1 for exactly the next cycle. start_i is ignored when not in IDLE or when ready_o=0.
- RUN, kernel done: k_done_i high in any RUN cycle sets kdone_seen. This includes the cycle k_start_o is high.
- RUN, beat counting: a beat on stream k is out_valid_i[k] & out_ready_i[k]. Streams count independently and simultaneously.
  - If cnt_k < len_q, cnt_k increments at the next edge, with no one-cycle delay.
  - If cnt_k == len_q, the count holds and err_o is set (sticky until next start, clear or reset).
- RUN → DONE when the registered values show kdone_seen=1 and cnt_k==len_q for all k. If the last beat and k_done_i coincide in cycle t, done_o is high in cycle t+2.
- len_q==0: all streams are complete immediately, so completion depends only on kdone_seen.
- DONE lasts one cycle. done_o=1 only in DONE. Next state is IDLE.
- Counters and k_id_o hold their values after DONE until the next accepted start or clear.
- Handshakes in IDLE or DONE are not counted and do not set err_o.
- busy_o = (state != IDLE), combinational from state.
- strb_o is combinational per stream:
  - low tail_q bits set, others 0, when state==RUN, tail_q!=0 and cnt_k == len_q-1 (the final beat).
  - all ones otherwise, including overflow beats and len_q==0.
- Counter arithmetic is unsigned CNT_W bits. It never wraps, because the increment is gated by the len_q compare. len_q = 2^CNT_W-1 is legal.

Test Plan:
- Basic job: N_OUT=2, len_i=4, tail_i=0; 4 beats per stream, k_done_i after the last beat → k_start_o 1 cycle after start; cnt_o=4/4; done_o one pulse; strb_o stays 0xF; busy_o low after DONE.
- Tail strobe: len_i=3, tail_i=2 → stream strobe is 0xF, 0xF, 0x3 on beats 1..3. Stream 1 lagging two cycles gets 0x3 on its own third beat.
- Coincident events: last beat on both streams in cycle t, with k_done_i pulse in the same cycle t → done_o high at t+2. Early k_done_i pulse before any beat, then 4 beats → done_o 2 cycles after the last beat.
- Overflow: len_i=2, 3 beats on stream 0 → cnt stays 2; err_o set and sticky through DONE; cleared by next start.
- Start gating: start_i while k_ready_i=k_idle_i=0, and start_i while in RUN → ignored, with no k_start_o and latched id unchanged. len_i=0 with k_done_i → done_o with counts 0.
- Abort: clear_i, and separately rst_i, mid-RUN after 2 beats → state IDLE, cnt_o=0, no done_o. Clear coincident with start → no job started.
